// File: rtl/tlul_sram_adapter.sv
// TL-UL device port to single-port SRAM req/gnt/rvalid bridge with in-order responses.
// Optional request legality checking is enabled by defining TLUL_SRAM_ERR_CHECK_EN.

package tlul_pkg;

   localparam logic [2:0] PutFullData    = 3'd0;
   localparam logic [2:0] PutPartialData = 3'd1;
   localparam logic [2:0] Get            = 3'd4;

   localparam logic [2:0] AccessAck     = 3'd0;
   localparam logic [2:0] AccessAckData = 3'd1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_sram_adapter
   import tlul_pkg::*;
#(
   parameter int SramAw      = 12,
   parameter int SramDw      = 32,
   parameter int Outstanding = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  tl_h2d_t           tl_i,
   output tl_d2h_t           tl_o,
   output logic              req_o,
   input  logic              gnt_i,
   output logic              we_o,
   output logic [SramAw-1:0] addr_o,
   output logic [SramDw-1:0] wdata_o,
   output logic [SramDw-1:0] wmask_o,
   input  logic [SramDw-1:0] rdata_i,
   input  logic              rvalid_i,
   input  logic [1:0]        rerror_i
);

   localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
   localparam int CntW = $clog2(Outstanding + 1);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(Outstanding);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);

   typedef struct packed {
      logic       rd;
      logic       err;
      logic [1:0] size;
      logic [7:0] source;
   } trk_t;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   logic a_err;

`ifdef TLUL_SRAM_ERR_CHECK_EN
   logic [3:0] size_mask;
   logic       op_err;
   logic       size_err;
   logic       align_err;
   logic       mask_err;
   logic       full_err;

   always_comb begin
      size_mask = 4'b0000;
      unique case (tl_i.a_size)
         2'd0:    size_mask = 4'b0001 << tl_i.a_address[1:0];
         2'd1:    size_mask = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
         2'd2:    size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   end

   assign op_err    = !(tl_i.a_opcode inside {PutFullData, PutPartialData, Get});
   assign size_err  = (tl_i.a_size == 2'd3);
   assign align_err = ((tl_i.a_size == 2'd1) & tl_i.a_address[0]) |
                      ((tl_i.a_size == 2'd2) & (|tl_i.a_address[1:0]));
   assign mask_err  = |(tl_i.a_mask & ~size_mask);
   assign full_err  = (tl_i.a_opcode == PutFullData) & (tl_i.a_mask != size_mask);

   assign a_err = tl_i.a_valid &
                  (op_err | size_err | align_err | mask_err | full_err);
`else
   assign a_err = 1'b0;
`endif

   trk_t            trk_q [Outstanding];
   logic [PtrW-1:0] trk_wr_q;
   logic [PtrW-1:0] trk_rd_q;
   logic [CntW-1:0] count_q;

   logic [31:0]     rdf_data_q [Outstanding];
   logic            rdf_err_q  [Outstanding];
   logic [PtrW-1:0] rdf_wr_q;
   logic [PtrW-1:0] rdf_rd_q;
   logic [CntW-1:0] rdf_cnt_q;

   logic [CntW-1:0] rd_pend_q;

   logic is_write;
   logic space;
   logic a_hs;
   logic d_hs;
   logic d_valid;
   trk_t hd;
   logic hd_data;
   logic rd_avail;
   logic rvalid_ok;
   logic rdf_push;
   logic rdf_pop;
   logic bypass_take;
   logic rd_issue;

   assign is_write = (tl_i.a_opcode == PutFullData) |
                     (tl_i.a_opcode == PutPartialData);

   assign hd        = trk_q[trk_rd_q];
   assign hd_data   = hd.rd & !hd.err;
   assign rd_avail  = (rdf_cnt_q != '0);
   assign rvalid_ok = rvalid_i & (rd_pend_q != '0);

   assign d_valid = (count_q != '0) & (!hd_data | rd_avail | rvalid_ok);
   assign d_hs    = d_valid & tl_i.d_ready;

   // Space frees up in the same cycle the head response leaves.
   assign space = (count_q < MaxCnt) | d_hs;
   assign a_hs  = tl_i.a_valid & (gnt_i | a_err) & space;

   assign req_o   = tl_i.a_valid & !a_err & space;
   assign we_o    = is_write;
   assign addr_o  = tl_i.a_address[SramAw+1:2];
   assign wdata_o = tl_i.a_data;

   always_comb begin
      wmask_o = '0;
      for (int i = 0; i < 4; i++) begin
         wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
      end
   end

   assign rd_issue    = a_hs & !a_err & !is_write;
   assign bypass_take = d_hs & hd_data & !rd_avail;
   assign rdf_push    = rvalid_ok & !bypass_take;
   assign rdf_pop     = d_hs & hd_data & rd_avail;

   always_comb begin
      tl_o          = '0;
      tl_o.a_ready  = (gnt_i | a_err) & space;
      tl_o.d_valid  = d_valid;
      tl_o.d_opcode = hd.rd ? AccessAckData : AccessAck;
      tl_o.d_size   = hd.size;
      tl_o.d_source = hd.source;
      tl_o.d_error  = hd.err;
      if (hd_data) begin
         if (rd_avail) begin
            tl_o.d_data  = rdf_data_q[rdf_rd_q];
            tl_o.d_error = rdf_err_q[rdf_rd_q];
         end else begin
            tl_o.d_data  = rdata_i;
            tl_o.d_error = |rerror_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (a_hs) begin
         trk_q[trk_wr_q] <= '{rd:     !is_write,
                              err:    a_err,
                              size:   tl_i.a_size,
                              source: tl_i.a_source};
      end
      if (rdf_push) begin
         rdf_data_q[rdf_wr_q] <= rdata_i;
         rdf_err_q[rdf_wr_q]  <= |rerror_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         trk_wr_q  <= '0;
         trk_rd_q  <= '0;
         count_q   <= '0;
         rdf_wr_q  <= '0;
         rdf_rd_q  <= '0;
         rdf_cnt_q <= '0;
         rd_pend_q <= '0;
      end else begin
         if (a_hs) trk_wr_q <= ptr_inc(trk_wr_q);
         if (d_hs) trk_rd_q <= ptr_inc(trk_rd_q);
         unique case ({a_hs, d_hs})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (rdf_push) rdf_wr_q <= ptr_inc(rdf_wr_q);
         if (rdf_pop)  rdf_rd_q <= ptr_inc(rdf_rd_q);
         unique case ({rdf_push, rdf_pop})
            2'b10:   rdf_cnt_q <= rdf_cnt_q + 1'b1;
            2'b01:   rdf_cnt_q <= rdf_cnt_q - 1'b1;
            default: rdf_cnt_q <= rdf_cnt_q;
         endcase

         unique case ({rd_issue, rvalid_ok})
            2'b10:   rd_pend_q <= rd_pend_q + 1'b1;
            2'b01:   rd_pend_q <= rd_pend_q - 1'b1;
            default: rd_pend_q <= rd_pend_q;
         endcase
      end
   end

   logic unused_addr;
   assign unused_addr = ^{tl_i.a_address[31:SramAw+2], tl_i.a_address[1:0]};

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// Directed self-checking bench for tlul_sram_adapter (Outstanding = 1).
// Error-response vectors are compiled when TLUL_SRAM_ERR_CHECK_EN is defined.

module tb_tlul_sram_adapter;
   import tlul_pkg::*;

   logic        clk;
   logic        rst_n;
   tl_h2d_t     tl_i;
   tl_d2h_t     tl_o;
   logic        req;
   logic        gnt;
   logic        we;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [31:0] wmask;
   logic [31:0] rdata;
   logic        rvalid;
   logic [1:0]  rerror;

   int n_checks = 0;
   int n_errors = 0;

   tlul_sram_adapter #(
      .SramAw(12),
      .SramDw(32),
      .Outstanding(1)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .tl_i(tl_i),
      .tl_o(tl_o),
      .req_o(req),
      .gnt_i(gnt),
      .we_o(we),
      .addr_o(addr),
      .wdata_o(wdata),
      .wmask_o(wmask),
      .rdata_i(rdata),
      .rvalid_i(rvalid),
      .rerror_i(rerror)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_a(input logic v, input logic [2:0] op,
                        input logic [1:0] sz, input logic [7:0] src,
                        input logic [31:0] ad, input logic [3:0] mk,
                        input logic [31:0] dt);
      tl_i.a_valid   = v;
      tl_i.a_opcode  = op;
      tl_i.a_size    = sz;
      tl_i.a_source  = src;
      tl_i.a_address = ad;
      tl_i.a_mask    = mk;
      tl_i.a_data    = dt;
   endtask

   task automatic idle_a();
      set_a(1'b0, Get, 2'd2, 8'd0, 32'h0, 4'hF, 32'h0);
   endtask

   initial begin
      rst_n  = 1'b0;
      tl_i   = '0;
      gnt    = 1'b0;
      rdata  = '0;
      rvalid = 1'b0;
      rerror = '0;
      idle_a();
      tl_i.d_ready = 1'b1;
      #1;
      chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_a_ready", 32'(tl_o.a_ready), 32'd0);

      cyc();
      cyc();
      rst_n = 1'b1;

      // Get 0x10 with data one cycle later
      cyc();
      gnt = 1'b1;
      set_a(1'b1, Get, 2'd2, 8'd5, 32'h0000_0010, 4'hF, 32'h0);
      #1;
      chk("get_req", 32'(req), 32'd1);
      chk("get_addr", 32'(addr), 32'd4);
      chk("get_we", 32'(we), 32'd0);
      chk("get_a_ready", 32'(tl_o.a_ready), 32'd1);
      cyc();
      idle_a();
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      #1;
      chk("get_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("get_d_opcode", 32'(tl_o.d_opcode), 32'd1);
      chk("get_d_data", tl_o.d_data, 32'hDEAD_BEEF);
      chk("get_d_source", 32'(tl_o.d_source), 32'd5);
      chk("get_d_size", 32'(tl_o.d_size), 32'd2);
      chk("get_d_error", 32'(tl_o.d_error), 32'd0);
      cyc();
      rvalid = 1'b0;
      #1;
      chk("get_done", 32'(tl_o.d_valid), 32'd0);

      // PutPartialData
      cyc();
      set_a(1'b1, PutPartialData, 2'd2, 8'd3, 32'h8, 4'b0101, 32'h1122_3344);
      #1;
      chk("ppd_wmask", wmask, 32'h00FF_00FF);
      chk("ppd_addr", 32'(addr), 32'd2);
      chk("ppd_we", 32'(we), 32'd1);
      chk("ppd_wdata", wdata, 32'h1122_3344);
      cyc();
      idle_a();
      #1;
      chk("ppd_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("ppd_d_opcode", 32'(tl_o.d_opcode), 32'd0);
      chk("ppd_d_data", tl_o.d_data, 32'h0);
      chk("ppd_d_source", 32'(tl_o.d_source), 32'd3);
      cyc();
      #1;
      chk("ppd_done", 32'(tl_o.d_valid), 32'd0);

      // Back-pressure: d_ready low for 3 cycles
      cyc();
      tl_i.d_ready = 1'b0;
      set_a(1'b1, Get, 2'd2, 8'd7, 32'h20, 4'hF, 32'h0);
      #1;
      chk("bp_a_ready0", 32'(tl_o.a_ready), 32'd1);
      cyc();
      set_a(1'b1, Get, 2'd2, 8'd8, 32'h24, 4'hF, 32'h0);
      rvalid = 1'b1;
      rdata  = 32'hCAFE_F00D;
      #1;
      chk("bp_a_ready1", 32'(tl_o.a_ready), 32'd0);
      chk("bp_d_valid1", 32'(tl_o.d_valid), 32'd1);
      chk("bp_d_data1", tl_o.d_data, 32'hCAFE_F00D);
      cyc();
      rvalid = 1'b0;
      rdata  = 32'h1234_5678;
      #1;
      chk("bp_a_ready2", 32'(tl_o.a_ready), 32'd0);
      chk("bp_d_data2", tl_o.d_data, 32'hCAFE_F00D);
      chk("bp_d_source2", 32'(tl_o.d_source), 32'd7);
      cyc();
      #1;
      chk("bp_a_ready3", 32'(tl_o.a_ready), 32'd0);
      chk("bp_d_valid3", 32'(tl_o.d_valid), 32'd1);
      tl_i.d_ready = 1'b1;
      #1;
      chk("bp_release_data", tl_o.d_data, 32'hCAFE_F00D);
      chk("bp_release_a_ready", 32'(tl_o.a_ready), 32'd1);
      cyc();
      idle_a();
      rvalid = 1'b1;
      rdata  = 32'h0BAD_CAFE;
      #1;
      chk("bp_next_source", 32'(tl_o.d_source), 32'd8);
      chk("bp_next_data", tl_o.d_data, 32'h0BAD_CAFE);
      cyc();
      rvalid = 1'b0;
      #1;
      chk("bp_done", 32'(tl_o.d_valid), 32'd0);

      // Read error from SRAM
      cyc();
      set_a(1'b1, Get, 2'd2, 8'd9, 32'h40, 4'hF, 32'h0);
      cyc();
      idle_a();
      rvalid = 1'b1;
      rdata  = 32'hA5A5_A5A5;
      rerror = 2'b10;
      #1;
      chk("rerr_d_error", 32'(tl_o.d_error), 32'd1);
      chk("rerr_d_data", tl_o.d_data, 32'hA5A5_A5A5);
      cyc();
      rvalid = 1'b0;
      rerror = 2'b00;

      // Grant stall
      cyc();
      gnt = 1'b0;
      set_a(1'b1, PutFullData, 2'd2, 8'd2, 32'h30, 4'hF, 32'h0102_0304);
      #1;
      chk("gnt0_a_ready", 32'(tl_o.a_ready), 32'd0);
      chk("gnt0_req", 32'(req), 32'd1);
      cyc();
      #1;
      chk("gnt0_no_resp", 32'(tl_o.d_valid), 32'd0);
      gnt = 1'b1;
      #1;
      chk("gnt1_a_ready", 32'(tl_o.a_ready), 32'd1);
      cyc();
      idle_a();
      #1;
      chk("gnt1_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("gnt1_d_opcode", 32'(tl_o.d_opcode), 32'd0);
      chk("gnt1_d_source", 32'(tl_o.d_source), 32'd2);
      cyc();
      #1;
      chk("gnt1_done", 32'(tl_o.d_valid), 32'd0);

      // Spurious rvalid must not pollute the data FIFO
      cyc();
      rvalid = 1'b1;
      rdata  = 32'h5555_5555;
      #1;
      chk("spur_d_valid", 32'(tl_o.d_valid), 32'd0);
      cyc();
      rvalid = 1'b0;
      set_a(1'b1, Get, 2'd2, 8'd4, 32'h44, 4'hF, 32'h0);
      cyc();
      idle_a();
      rvalid = 1'b1;
      rdata  = 32'h6666_6666;
      #1;
      chk("spur_next_data", tl_o.d_data, 32'h6666_6666);
      cyc();
      rvalid = 1'b0;

`ifdef TLUL_SRAM_ERR_CHECK_EN
      // Misaligned Get and short PutFullData are answered with errors
      cyc();
      gnt = 1'b0;
      set_a(1'b1, Get, 2'd2, 8'd6, 32'h2, 4'hF, 32'h0);
      #1;
      chk("err_get_req", 32'(req), 32'd0);
      chk("err_get_a_ready", 32'(tl_o.a_ready), 32'd1);
      cyc();
      idle_a();
      #1;
      chk("err_get_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("err_get_d_opcode", 32'(tl_o.d_opcode), 32'd1);
      chk("err_get_d_error", 32'(tl_o.d_error), 32'd1);
      chk("err_get_d_data", tl_o.d_data, 32'h0);
      cyc();
      set_a(1'b1, PutFullData, 2'd2, 8'd1, 32'h0, 4'b0011, 32'hFFFF_FFFF);
      #1;
      chk("err_pfd_req", 32'(req), 32'd0);
      cyc();
      idle_a();
      #1;
      chk("err_pfd_d_opcode", 32'(tl_o.d_opcode), 32'd0);
      chk("err_pfd_d_error", 32'(tl_o.d_error), 32'd1);
      cyc();
      gnt = 1'b1;
`else
      // Without checking, a misaligned Get is forwarded
      cyc();
      set_a(1'b1, Get, 2'd2, 8'd6, 32'h2, 4'hF, 32'h0);
      #1;
      chk("nochk_req", 32'(req), 32'd1);
      chk("nochk_addr", 32'(addr), 32'd0);
      cyc();
      idle_a();
      rvalid = 1'b1;
      rdata  = 32'h0000_0077;
      #1;
      chk("nochk_d_error", 32'(tl_o.d_error), 32'd0);
      chk("nochk_d_data", tl_o.d_data, 32'h0000_0077);
      cyc();
      rvalid = 1'b0;
`endif

      // Reset with a read in flight discards it
      cyc();
      set_a(1'b1, Get, 2'd2, 8'd3, 32'h50, 4'hF, 32'h0);
      cyc();
      idle_a();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
      cyc();
      rst_n  = 1'b1;
      rvalid = 1'b1;
      rdata  = 32'h9999_9999;
      #1;
      chk("post_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
      cyc();
      rvalid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tlul_sram_adapter.md
# tlul_sram_adapter

Bridges a TileLink Uncached Lightweight (TL-UL) device port to a simple single-port SRAM request/grant/rvalid interface. It sits between the bus crossbar and on-chip memories such as the main block RAM. It translates Get, PutFullData and PutPartialData into word-addressed SRAM accesses with a bit-level write mask, and returns in-order AccessAck/AccessAckData responses with a bounded number of outstanding requests.

## Interface
- SramAw, 12, SRAM word-address width
- SramDw, 32, SRAM data width; only 32 is supported
- Outstanding, 1, maximum requests accepted but not yet answered on the D channel (≥1)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- tl_i  in  tlul_pkg::tl_h2d_t  A channel (a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data) and d_ready
- tl_o  out  tlul_pkg::tl_d2h_t  D channel (d_valid, d_opcode, d_size, d_source, d_data, d_error) and a_ready
- req_o  out  1  SRAM request
- gnt_i  in  1  SRAM grant
- we_o  out  1  write enable
- addr_o  out  SramAw  word address, equal to a_address[SramAw+1:2]
- wdata_o  out  SramDw  equal to a_data
- wmask_o  out  SramDw  bit mask; byte i is all ones when a_mask[i] is set
- rdata_i  in  SramDw  read data
- rvalid_i  in  1  read data valid, exactly one per granted read
- rerror_i  in  2  read error; any bit set flags an error

## Operation
- Tracking: an in-order request FIFO of depth Outstanding. Each entry stores opcode (read/write), a_size, a_source and error flag.
- Read data: a response data FIFO of depth Outstanding, with combinational bypass when it is empty.
- Acceptance:
  - a_ready = (gnt_i | error) & (count < Outstanding | D handshake this cycle).
  - A handshake is a_valid & a_ready.
- SRAM request: req_o = a_valid & !error & (tracking space available). we_o = 1 for PutFullData (0) and PutPartialData (1).
- Error detection (when enabled):
  - opcode not in {0,1,4};
  - a_size > 2;
  - address not aligned to a_size;
  - a_mask bits outside the addressed size/offset;
  - PutFullData whose mask does not cover the full size.
- An errored request is not forwarded (req_o = 0). It is acknowledged with d_error = 1 and d_data = 0, using the opcode's normal response type.
- Responses:
  - Strictly in request order.
  - Get returns AccessAckData (1) with d_data = rdata_i and d_error = |rerror_i.
  - Puts return AccessAck (0) with d_data = 0.
  - d_size and d_source are echoed from the request.
- A write response is ready as soon as its tracking entry exists. A read response waits for its rvalid data.
- Read data arriving while d_ready = 0 is held in the data FIFO. rvalid_i with no pending read is ignored.

## Timing
- Reset: d_valid = 0, req_o = 0, count = 0, both FIFOs empty. a_ready follows its equation, so it is 0 when gnt_i = 0.
- req_o, we_o, addr_o, wdata_o and wmask_o are combinational from the A channel. No registered stage is added.
- Read accepted at cycle N with rvalid_i at N+1: d_valid at N+1, with data passed through combinationally.
- Write accepted at cycle N: d_valid at N+1.
- Errored request accepted at cycle N: d_valid at N+1.
- With Outstanding = 1 and d_ready held at 1, one request can be accepted per cycle after the first response. With d_ready = 0, a_ready stays 0 until the response is taken.
- d_valid and the D fields stay stable until d_ready.
- An asynchronous reset mid-transaction discards all pending entries. No response is produced for them.

## Configuration
- TLUL_SRAM_ERR_CHECK_EN
  - Defined: the error detection above is active.
  - Undefined: every request is treated as legal and forwarded. d_error is driven only by rerror_i on reads.

## Test plan
- Get at 0x0000_0010, size 2, source 5; rdata_i = 0xDEADBEEF at N+1 → addr_o = 4, we_o = 0, D: opcode 1, data 0xDEADBEEF, source 5, error 0.
- PutPartialData at 0x8, mask 0b0101, data 0x11223344 → wmask_o = 0x00FF00FF, addr_o = 2, we_o = 1, AccessAck at N+1.
- Get with d_ready = 0 for 3 cycles → a_ready = 0 throughout; data held; delivered unchanged when d_ready rises.
- Get at 0x2 with size 2 (error checking enabled) → req_o = 0, AccessAckData with d_error = 1, data 0.
- Get with rerror_i = 2'b10 → d_error = 1.
- gnt_i = 0 with a_valid = 1 → a_ready = 0 and no response; completes when gnt_i rises.
